// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and types for the decode/issue stage.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {ID_EMPTY = 1'b0, ID_FULL = 1'b1} id_state_e;

    // R-type field layout; other formats reuse the same bit positions for rd/rs1/rs2.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_fields_t;

endpackage

// File: rtl/instruction_parser.sv
// Splits a 32-bit RV32I instruction word into its fixed-position fields.
module instruction_parser
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output rv_fields_t  fields_o
);

    assign fields_o = instr_i;

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue control: IF/ID register, load-use bubble insertion,
// EX branch flush and a bubble counter.
module id_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_instr_i,
    input  logic [31:0]      if_pc_i,
    output logic             if_ready_o,
    output logic             id_valid_o,
    output logic [31:0]      id_instr_o,
    output logic [31:0]      id_pc_o,
    output logic [4:0]       id_rs1_o,
    output logic [4:0]       id_rs2_o,
    output logic [4:0]       id_rd_o,
    input  logic             id_ready_i,
    input  logic             ex_flush_i,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    id_state_e        state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [4:0]       pend_rd_q, pend_rd_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    rv_fields_t f;
    logic hold_valid, uses_rs1, uses_rs2, hazard, issue, accept;

    instruction_parser u_parser (
        .instr_i  (instr_q),
        .fields_o (f)
    );

    assign hold_valid = (state_q == ID_FULL);
    assign uses_rs1   = !(f.opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign uses_rs2   = f.opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    assign hazard     = hold_valid && pend_valid_q && (pend_rd_q != 5'd0) &&
                        ((uses_rs1 && (f.rs1 == pend_rd_q)) ||
                         (uses_rs2 && (f.rs2 == pend_rd_q)));

    assign id_valid_o = hold_valid && !hazard && !ex_flush_i;
    assign issue      = id_valid_o && id_ready_i;
    assign if_ready_o = !ex_flush_i && (!hold_valid || issue);
    assign accept     = if_valid_i && if_ready_o;

    assign id_instr_o   = f;
    assign id_pc_o      = pc_q;
    assign id_rs1_o     = f.rs1;
    assign id_rs2_o     = f.rs2;
    assign id_rd_o      = f.rd;
    assign bubble_cnt_o = bubble_cnt_q;

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_rd_d    = pend_rd_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ex_flush_i) begin
            state_d      = ID_EMPTY;
            pend_valid_d = 1'b0;
        end else begin
            if (accept) begin
                state_d = ID_FULL;
                instr_d = if_instr_i;
                pc_d    = if_pc_i;
            end else if (issue) begin
                state_d = ID_EMPTY;
            end
            // The tracker only advances when EX advances, so a stall keeps the hazard alive.
            if (id_ready_i) begin
                pend_valid_d = issue && (f.opcode == OPC_LOAD) && (f.rd != 5'd0);
                pend_rd_d    = f.rd;
                if (hazard) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ID_EMPTY;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_rd_q    <= 5'd0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench for id_issue_ctrl: directed scenarios plus random traffic against a reference model.
module tb_id_issue_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0, reset = 1'b1;
    logic        if_valid = 1'b0, id_ready = 1'b0, ex_flush = 1'b0;
    logic [31:0] if_instr = 32'd0, if_pc = 32'd0;
    logic        if_ready, id_valid;
    logic [31:0] id_instr, id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] bubble_cnt;

    id_issue_ctrl #(.CNT_W(16)) dut (
        .clk_i(clk), .reset_i(reset), .if_valid_i(if_valid), .if_instr_i(if_instr),
        .if_pc_i(if_pc), .if_ready_o(if_ready), .id_valid_o(id_valid), .id_instr_o(id_instr),
        .id_pc_o(id_pc), .id_rs1_o(id_rs1), .id_rs2_o(id_rs2), .id_rd_o(id_rd),
        .id_ready_i(id_ready), .ex_flush_i(ex_flush), .bubble_cnt_o(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] ins; logic [31:0] pc; } ent_t;
    ent_t expq[$];

    int total = 0, bad = 0;
    logic [31:0] pc_ctr = 32'h1000;

    // Reference model: the held slot, the load most recently sent to EX, and the bubble tally.
    bit          mhold, mpend;
    logic [4:0]  mpend_rd;
    logic [31:0] minstr, mpc;
    logic [15:0] mcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            default: return 5'd5;
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0] op;
        case ($urandom_range(0, 9))
            0, 1: op = OPC_LOAD;
            2: op = OPC_STORE;
            3: op = OPC_OP;
            4: op = OPC_OP_IMM;
            5: op = OPC_BRANCH;
            6: op = OPC_LUI;
            7: op = OPC_AUIPC;
            8: op = OPC_JAL;
            default: op = OPC_JALR;
        endcase
        return enc(op, rreg(), rreg(), rreg());
    endfunction

    function automatic void model_reset();
        mhold = 0; mpend = 0; mpend_rd = 0; minstr = NOP_INSTR; mpc = 0; mcnt = 0;
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, output bit acc);
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
        bit u1, u2, hz, eidv, iss, eifr;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy; ex_flush = fl;
        #1;
        op = minstr[6:0]; rd = minstr[11:7]; rs1 = minstr[19:15]; rs2 = minstr[24:20];
        u1 = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
        u2 = (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH);
        hz = mhold && mpend && mpend_rd != 0 && ((u1 && rs1 == mpend_rd) || (u2 && rs2 == mpend_rd));
        eidv = mhold && !hz && !fl;
        iss  = eidv && rdy;
        eifr = !fl && (!mhold || iss);
        chk("id_valid", {31'd0, id_valid}, {31'd0, eidv});
        chk("if_ready", {31'd0, if_ready}, {31'd0, eifr});
        chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, mcnt});
        chk("id_instr", id_instr, minstr);
        chk("id_pc", id_pc, mpc);
        chk("id_fields", {17'd0, id_rs1, id_rs2, id_rd}, {17'd0, rs1, rs2, rd});
        acc = v && eifr;
        if (fl) begin
            if (mhold && expq.size() > 0) void'(expq.pop_back());
            mhold = 0; mpend = 0;
        end else begin
            if (acc) begin
                mhold = 1; minstr = ins; mpc = pc;
                expq.push_back('{ins: ins, pc: pc});
            end else if (iss) begin
                mhold = 0;
            end
            if (rdy) begin
                mpend = iss && op == OPC_LOAD && rd != 0;
                mpend_rd = rd;
                if (hz) mcnt++;
            end
        end
    endtask

    task automatic idle(input logic rdy);
        bit acc;
        step(0, 32'd0, 32'd0, rdy, 0, acc);
    endtask

    task automatic offer(input logic [31:0] ins, input logic rdy);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 20) begin
            step(1, ins, pc_ctr, rdy, 0, acc);
            n++;
        end
        chk("offer_accepted", {31'd0, acc}, 32'd1);
        pc_ctr += 4;
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic rst_mid();
        @(negedge clk);
        if_valid = 0; id_ready = 0; ex_flush = 0;
        #3 reset = 1;
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
        chk("rst_id_instr", id_instr, NOP_INSTR);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        model_reset();
        expq.delete();
        @(negedge clk);
        reset = 0;
    endtask

    // Issue monitor: every DUT issue must match the oldest accepted, not-yet-flushed fetch.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && id_valid && id_ready) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL issue_unexpected: got pc %h want no issue", id_pc);
                end else begin
                    e = expq.pop_front();
                    chk("issue_instr", id_instr, e.ins);
                    chk("issue_pc", id_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc, cv;
        logic [31:0] ci, cp;
        logic rdy, fl;
        model_reset();
        @(negedge clk);
        reset = 0;
        #1;
        chk("init_id_valid", {31'd0, id_valid}, 32'd0);
        chk("init_if_ready", {31'd0, if_ready}, 32'd1);
        chk("init_id_instr", id_instr, NOP_INSTR);
        chk("init_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);

        // Streaming ADDIs
        for (int i = 0; i < 4; i++) offer(enc(OPC_OP_IMM, 5'(i + 1), 5'd0, 5'd1), 1);
        idle(1); idle(1);
        chk("stream_bubbles", {16'd0, bubble_cnt}, 32'd0);

        // Load-use: LW x5 then ADD x6,x5,x2
        offer(enc(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1);
        offer(enc(OPC_OP, 5'd6, 5'd5, 5'd2), 1);
        idle(1); idle(1);
        chk("lu_bubbles", {16'd0, bubble_cnt}, 32'd1);

        // No false hazards
        rst_mid();
        offer(enc(OPC_LOAD, 5'd0, 5'd1, 5'd0), 1);
        offer(enc(OPC_OP, 5'd6, 5'd0, 5'd0), 1);
        offer(enc(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1);
        offer(enc(OPC_LUI, 5'd5, 5'd5, 5'd5), 1);
        offer(enc(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1);
        offer(enc(OPC_OP_IMM, 5'd7, 5'd3, 5'd5), 1);
        idle(1); idle(1);
        chk("nofalse_bubbles", {16'd0, bubble_cnt}, 32'd0);

        // Backpressure with a held instruction, then a stalled dependent load
        rst_mid();
        offer(enc(OPC_OP_IMM, 5'd1, 5'd0, 5'd1), 0);
        for (int i = 0; i < 3; i++) step(1, enc(OPC_OP_IMM, 5'd2, 5'd0, 5'd2), pc_ctr, 0, 0, acc);
        offer(enc(OPC_OP_IMM, 5'd2, 5'd0, 5'd2), 1);
        idle(1);
        offer(enc(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1);
        offer(enc(OPC_STORE, 5'd0, 5'd1, 5'd5), 1);
        for (int i = 0; i < 3; i++) idle(0);
        idle(1); idle(1);
        chk("bp_bubbles", {16'd0, bubble_cnt}, 32'd1);

        // Flush drops both the held and the offered instruction; flush beats hazard
        rst_mid();
        offer(enc(OPC_OP_IMM, 5'd1, 5'd0, 5'd1), 0);
        step(1, enc(OPC_LUI, 5'd3, 5'd0, 5'd0), pc_ctr, 1, 1, acc);
        idle(1); idle(1);
        offer(enc(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1);
        offer(enc(OPC_OP, 5'd6, 5'd5, 5'd2), 1);
        step(0, 32'd0, 32'd0, 1, 1, acc);
        idle(1);
        chk("flush_hz_bubbles", {16'd0, bubble_cnt}, 32'd0);

        // Reset while a hazard is pending
        offer(enc(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1);
        offer(enc(OPC_OP, 5'd6, 5'd5, 5'd2), 1);
        rst_mid();

        // Random traffic
        cv = 0; ci = 0; cp = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!cv && $urandom_range(0, 4) != 0) begin
                cv = 1; ci = rand_ins(); cp = pc_ctr; pc_ctr += 4;
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            step(cv, cv ? ci : 32'd0, cv ? cp : 32'd0, rdy, fl, acc);
            if (acc || fl) cv = 0;
        end
        idle(1); idle(1); idle(1);
        chk("drain_queue", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
